// File: rtl/rs_tag_allocator_pkg.sv
// Shared reservation-station defines used by the tag allocator, the reservation
// stations and dispatch: pool geometry, tag encoding and per-pool slot state.
package rs_tag_allocator_pkg;

  localparam int RS_SIZE = 6;
  localparam int TAG_W   = 3;
  localparam int CNT_W   = $clog2(RS_SIZE + 1);

  localparam logic [TAG_W-1:0] NO_FREE_TAG = 3'b111;

  typedef logic [RS_SIZE-1:0] slot_vec_t;
  typedef logic [TAG_W-1:0]   tag_t;
  typedef logic [CNT_W-1:0]   cnt_t;

  typedef enum logic {
    POOL_ALU = 1'b0,
    POOL_LS  = 1'b1
  } pool_e;

  typedef struct packed {
    slot_vec_t freeVec;
    cnt_t      freeCnt;
  } pool_state_t;

  localparam pool_state_t POOL_RESET = '{freeVec: '1, freeCnt: cnt_t'(RS_SIZE)};

  // Tags at or beyond RS_SIZE shift out of the vector, giving an all-zero mask.
  function automatic slot_vec_t tagToMask(tag_t tag);
    return slot_vec_t'(1) << tag;
  endfunction

  // Alloc and release never target the same slot, so count moves by +1, -1 or 0.
  function automatic pool_state_t nextPool(pool_state_t cur, logic flushEn,
                                           logic allocEn, tag_t allocTag,
                                           logic relEn, tag_t relTag);
    pool_state_t nxt;
    nxt = cur;
    if (flushEn) begin
      nxt = POOL_RESET;
    end else begin
      if (allocEn) begin
        nxt.freeVec = nxt.freeVec & ~tagToMask(allocTag);
      end
      if (relEn) begin
        nxt.freeVec = nxt.freeVec | tagToMask(relTag);
      end
      nxt.freeCnt = cur.freeCnt + cnt_t'(relEn) - cnt_t'(allocEn);
    end
    return nxt;
  endfunction

endpackage

// File: rtl/rs_free_pick.sv
// Lowest-set-bit encoder over one pool's free bitmap; reports NO_FREE_TAG when
// the pool is exhausted.
module rs_free_pick
  import rs_tag_allocator_pkg::*;
(
  input  logic [RS_SIZE-1:0] free_vec_i,
  output logic [TAG_W-1:0]   tag_o,
  output logic               nonempty_o
);

  // Scan from the top down so the lowest free index is the last one written.
  always_comb begin
    tag_o = NO_FREE_TAG;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (free_vec_i[i]) begin
        tag_o = TAG_W'(i);
      end
    end
  end

  assign nonempty_o = |free_vec_i;

endmodule

// File: rtl/rs_tag_allocator.sv
// Free/busy bookkeeping for the ALU and LS reservation-station pools: grants
// the lowest free slot to dispatch, frees slots on issue and on flush.
module rs_tag_allocator
  import rs_tag_allocator_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               disp_req,
  input  logic               disp_is_ls,
  output logic               disp_grant,
  output logic [TAG_W-1:0]   disp_tag,
  output logic               disp_stall,
  input  logic               alu_rel_vld,
  input  logic [TAG_W-1:0]   alu_rel_tag,
  input  logic               ls_rel_vld,
  input  logic [TAG_W-1:0]   ls_rel_tag,
  output logic [RS_SIZE-1:0] alu_free_vec,
  output logic [RS_SIZE-1:0] ls_free_vec,
  output logic [CNT_W-1:0]   alu_free_cnt,
  output logic [CNT_W-1:0]   ls_free_cnt,
  output logic               err_rel
);

  pool_state_t aluPool_q, aluPool_d;
  pool_state_t lsPool_q, lsPool_d;
  logic        errRel_q, errRel_d;

  tag_t  aluPickTag, lsPickTag, pickTag;
  logic  aluNonEmpty, lsNonEmpty, poolNonEmpty;
  logic  aluRelLegal, lsRelLegal, aluRelBad, lsRelBad;
  logic  aluAlloc, lsAlloc;
  pool_e dispPool;

  rs_free_pick u_alu_pick (
    .free_vec_i (aluPool_q.freeVec),
    .tag_o      (aluPickTag),
    .nonempty_o (aluNonEmpty)
  );

  rs_free_pick u_ls_pick (
    .free_vec_i (lsPool_q.freeVec),
    .tag_o      (lsPickTag),
    .nonempty_o (lsNonEmpty)
  );

  // Zero-latency grant from registered state; rst and flush mask the request.
  always_comb begin
    dispPool     = pool_e'(disp_is_ls);
    poolNonEmpty = (dispPool == POOL_LS) ? lsNonEmpty : aluNonEmpty;
    pickTag      = (dispPool == POOL_LS) ? lsPickTag  : aluPickTag;
    disp_grant   = disp_req & poolNonEmpty & ~flush & ~rst;
    disp_stall   = disp_req & ~poolNonEmpty & ~flush & ~rst;
    disp_tag     = disp_grant ? pickTag : NO_FREE_TAG;
    aluAlloc     = disp_grant & (dispPool == POOL_ALU);
    lsAlloc      = disp_grant & (dispPool == POOL_LS);
  end

  // A release is legal only if it names an in-range slot that is currently busy.
  always_comb begin
    aluRelLegal = alu_rel_vld & |(tagToMask(alu_rel_tag) & ~aluPool_q.freeVec);
    lsRelLegal  = ls_rel_vld  & |(tagToMask(ls_rel_tag)  & ~lsPool_q.freeVec);
    aluRelBad   = alu_rel_vld & ~aluRelLegal;
    lsRelBad    = ls_rel_vld  & ~lsRelLegal;
  end

  always_comb begin
    aluPool_d = nextPool(aluPool_q, flush, aluAlloc, aluPickTag, aluRelLegal, alu_rel_tag);
    lsPool_d  = nextPool(lsPool_q,  flush, lsAlloc,  lsPickTag,  lsRelLegal,  ls_rel_tag);
    errRel_d  = errRel_q | aluRelBad | lsRelBad;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      aluPool_q <= POOL_RESET;
      lsPool_q  <= POOL_RESET;
      errRel_q  <= 1'b0;
    end else begin
      aluPool_q <= aluPool_d;
      lsPool_q  <= lsPool_d;
      errRel_q  <= errRel_d;
    end
  end

  assign alu_free_vec = aluPool_q.freeVec;
  assign ls_free_vec  = lsPool_q.freeVec;
  assign alu_free_cnt = aluPool_q.freeCnt;
  assign ls_free_cnt  = lsPool_q.freeCnt;
  assign err_rel      = errRel_q;

endmodule

// File: tb/tb_rs_tag_allocator.sv
// Randomised and directed bench for rs_tag_allocator: a per-slot reference
// model predicts each cycle's outputs into a queue drained by a monitor.
module tb_rs_tag_allocator;
  import rs_tag_allocator_pkg::*;

  logic               clk;
  logic               rst;
  logic               flush;
  logic               disp_req;
  logic               disp_is_ls;
  logic               disp_grant;
  logic [TAG_W-1:0]   disp_tag;
  logic               disp_stall;
  logic               alu_rel_vld;
  logic [TAG_W-1:0]   alu_rel_tag;
  logic               ls_rel_vld;
  logic [TAG_W-1:0]   ls_rel_tag;
  logic [RS_SIZE-1:0] alu_free_vec;
  logic [RS_SIZE-1:0] ls_free_vec;
  logic [CNT_W-1:0]   alu_free_cnt;
  logic [CNT_W-1:0]   ls_free_cnt;
  logic               err_rel;

  typedef struct {
    bit grant;
    int tag;
    bit stall;
    int aluVec;
    int lsVec;
    int aluCnt;
    int lsCnt;
    bit err;
  } exp_t;

  exp_t expQ[$];
  bit   freeSlot[2][RS_SIZE];
  bit   modelErr;
  int   testsRun;
  int   testsFailed;

  rs_tag_allocator dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .disp_req     (disp_req),
    .disp_is_ls   (disp_is_ls),
    .disp_grant   (disp_grant),
    .disp_tag     (disp_tag),
    .disp_stall   (disp_stall),
    .alu_rel_vld  (alu_rel_vld),
    .alu_rel_tag  (alu_rel_tag),
    .ls_rel_vld   (ls_rel_vld),
    .ls_rel_tag   (ls_rel_tag),
    .alu_free_vec (alu_free_vec),
    .ls_free_vec  (ls_free_vec),
    .alu_free_cnt (alu_free_cnt),
    .ls_free_cnt  (ls_free_cnt),
    .err_rel      (err_rel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(string name, int actual, int expected);
    testsRun++;
    if (actual != expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic modelReset();
    for (int p = 0; p < 2; p++)
      for (int i = 0; i < RS_SIZE; i++)
        freeSlot[p][i] = 1'b1;
    modelErr = 1'b0;
  endtask

  function automatic int modelPick(int pool);
    for (int i = 0; i < RS_SIZE; i++)
      if (freeSlot[pool][i]) return i;
    return 7;
  endfunction

  function automatic int modelVec(int pool);
    int v = 0;
    for (int i = 0; i < RS_SIZE; i++)
      if (freeSlot[pool][i]) v += (1 << i);
    return v;
  endfunction

  function automatic int modelCount(int pool);
    int c = 0;
    for (int i = 0; i < RS_SIZE; i++)
      if (freeSlot[pool][i]) c++;
    return c;
  endfunction

  function automatic bit modelRelLegal(int pool, int tag);
    if (tag >= RS_SIZE) return 1'b0;
    return !freeSlot[pool][tag];
  endfunction

  function automatic int randomBusy(int pool);
    int busy[$];
    for (int i = 0; i < RS_SIZE; i++)
      if (!freeSlot[pool][i]) busy.push_back(i);
    if (busy.size() == 0) return -1;
    return busy[$urandom_range(0, busy.size() - 1)];
  endfunction

  // Drive one cycle of inputs, predict what the DUT shows this cycle, then
  // advance the model to the state after the coming rising edge.
  task automatic applyStimulus(bit fl, bit req, bit isLs, bit aVld, int aTag, bit lVld, int lTag);
    exp_t e;
    int   pool;
    int   pick;
    bit   aLegal;
    bit   lLegal;
    @(posedge clk);
    #1;
    flush       = fl;
    disp_req    = req;
    disp_is_ls  = isLs;
    alu_rel_vld = aVld;
    alu_rel_tag = TAG_W'(aTag);
    ls_rel_vld  = lVld;
    ls_rel_tag  = TAG_W'(lTag);

    pool     = isLs ? 1 : 0;
    pick     = modelPick(pool);
    e.grant  = req && (pick < RS_SIZE) && !fl;
    e.stall  = req && (pick >= RS_SIZE) && !fl;
    e.tag    = e.grant ? pick : 7;
    e.aluVec = modelVec(0);
    e.lsVec  = modelVec(1);
    e.aluCnt = modelCount(0);
    e.lsCnt  = modelCount(1);
    e.err    = modelErr;
    expQ.push_back(e);

    aLegal = aVld && modelRelLegal(0, aTag);
    lLegal = lVld && modelRelLegal(1, lTag);
    if (aVld && !aLegal) modelErr = 1'b1;
    if (lVld && !lLegal) modelErr = 1'b1;
    if (fl) begin
      for (int p = 0; p < 2; p++)
        for (int i = 0; i < RS_SIZE; i++)
          freeSlot[p][i] = 1'b1;
    end else begin
      if (e.grant) freeSlot[pool][pick] = 1'b0;
      if (aLegal) freeSlot[0][aTag] = 1'b1;
      if (lLegal) freeSlot[1][lTag] = 1'b1;
    end
  endtask

  task automatic idle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic checkResetOutputs(string where);
    checkOutput({where, " disp_grant"}, disp_grant, 0);
    checkOutput({where, " disp_stall"}, disp_stall, 0);
    checkOutput({where, " disp_tag"}, disp_tag, 7);
    checkOutput({where, " alu_free_vec"}, alu_free_vec, 63);
    checkOutput({where, " ls_free_vec"}, ls_free_vec, 63);
    checkOutput({where, " alu_free_cnt"}, alu_free_cnt, 6);
    checkOutput({where, " ls_free_cnt"}, ls_free_cnt, 6);
    checkOutput({where, " err_rel"}, err_rel, 0);
  endtask

  // Monitor: every falling edge out of reset, compare against the oldest prediction.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && expQ.size() > 0) begin
      e = expQ.pop_front();
      checkOutput("disp_grant", disp_grant, e.grant);
      checkOutput("disp_tag", disp_tag, e.tag);
      checkOutput("disp_stall", disp_stall, e.stall);
      checkOutput("alu_free_vec", alu_free_vec, e.aluVec);
      checkOutput("ls_free_vec", ls_free_vec, e.lsVec);
      checkOutput("alu_free_cnt", alu_free_cnt, e.aluCnt);
      checkOutput("ls_free_cnt", ls_free_cnt, e.lsCnt);
      checkOutput("err_rel", err_rel, e.err);
    end
  end

  initial begin
    int aTag;
    int lTag;
    testsRun    = 0;
    testsFailed = 0;
    rst         = 1'b1;
    flush       = 1'b0;
    disp_req    = 1'b1;
    disp_is_ls  = 1'b0;
    alu_rel_vld = 1'b0;
    alu_rel_tag = '0;
    ls_rel_vld  = 1'b0;
    ls_rel_tag  = '0;
    modelReset();
    #3;
    checkResetOutputs("reset");
    @(posedge clk);
    #1;
    rst      = 1'b0;
    disp_req = 1'b0;

    // Fill the ALU pool, then one more request must stall.
    repeat (6) applyStimulus(0, 1, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 0, 0, 0);

    // Full pool: release tag 3 stalls this cycle, grants tag 3 the next.
    applyStimulus(0, 1, 0, 1, 3, 0, 0);
    applyStimulus(0, 1, 0, 0, 0, 0, 0);
    idle();

    // Reach free_vec 000110, then alloc and release in the same cycle.
    applyStimulus(0, 0, 0, 1, 1, 0, 0);
    applyStimulus(0, 0, 0, 1, 2, 0, 0);
    applyStimulus(0, 1, 0, 1, 5, 0, 0);
    idle();

    // Four LS slots busy, then flush with a request and a release pending.
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    repeat (4) applyStimulus(0, 1, 1, 0, 0, 0, 0);
    applyStimulus(1, 1, 1, 0, 0, 1, 0);
    idle();

    // Random traffic with legal releases and occasional flushes.
    for (int n = 0; n < 400; n++) begin
      aTag = randomBusy(0);
      lTag = randomBusy(1);
      applyStimulus($urandom_range(0, 39) == 0, 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)),
                    (aTag >= 0) && ($urandom_range(0, 2) == 0), (aTag < 0) ? 0 : aTag,
                    (lTag >= 0) && ($urandom_range(0, 2) == 0), (lTag < 0) ? 0 : lTag);
    end

    // Invalid releases make err_rel sticky without touching the vectors.
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 2, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 1, 6);
    repeat (3) idle();

    // Async reset mid-stream with ALU free_vec 000001 and a request pending.
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    repeat (6) applyStimulus(0, 1, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 0, 0, 0);
    idle();
    @(negedge clk);
    #1;
    checkOutput("pre-reset alu_free_vec", alu_free_vec, 1);
    disp_req   = 1'b1;
    disp_is_ls = 1'b0;
    #1;
    rst = 1'b1;
    #1;
    checkResetOutputs("async reset");
    @(posedge clk);
    #1;
    rst      = 1'b0;
    disp_req = 1'b0;
    modelReset();
    applyStimulus(0, 1, 0, 0, 0, 0, 0);
    idle();

    @(negedge clk);
    #1;
    checkOutput("queue drained", expQ.size(), 0);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
